dmem_access: RTL and testbench

- Memory-stage data-bus master for loads and stores. It issues one request per memory instruction on the split address/data handshake data bus.
- For stores, it aligns store data and generates byte strobes for SB/SH/SW.
- For loads, it captures the raw 32-bit read word and its byte offset. The writeback stage applies byte/halfword extraction and sign extension.
- It stalls the pipeline while a transaction is outstanding.

---
 rtl/dmem_access_if.sv | 26 ++
 rtl/dmem_access.sv | 169 ++++++++++++++++
 tb/tb_dmem_access.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_if.sv
// Split address/data handshake data bus between the memory stage (master)
// and the data memory (slave).
interface dmem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access.sv
// Memory-stage load/store bus master: issues one bus transaction per memory op,
// aligns store data/strobes, captures the raw load word and stalls while busy.
`ifndef W_OPER
`define W_OPER 4
`endif

module dmem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [`W_OPER-1:0]  oper,
  input  logic                mem_en,
  input  logic                flush,
  input  logic                hold,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   st_data,
  output logic                stall_req,
  output logic                addr_err,
  dmem_access_if.master       bus,
  output logic [DATA_W-1:0]   ld_word,
  output logic [1:0]          word_offset
);

  localparam logic [`W_OPER-1:0] OP_LB  = `W_OPER'(1);
  localparam logic [`W_OPER-1:0] OP_LBU = `W_OPER'(2);
  localparam logic [`W_OPER-1:0] OP_LH  = `W_OPER'(3);
  localparam logic [`W_OPER-1:0] OP_LHU = `W_OPER'(4);
  localparam logic [`W_OPER-1:0] OP_LW  = `W_OPER'(5);
  localparam logic [`W_OPER-1:0] OP_SB  = `W_OPER'(6);
  localparam logic [`W_OPER-1:0] OP_SH  = `W_OPER'(7);
  localparam logic [`W_OPER-1:0] OP_SW  = `W_OPER'(8);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_r, next_s;
  logic              cancel_r, cancel_s;
  logic              is_ld_s, is_st_s, misalign_s, start_s, finish_s, ld_cap_s;
  logic [1:0]        size_s;
  logic              req_r, wr_r;
  logic [1:0]        size_r, offset_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, ld_word_r;
  logic [3:0]        wstrb_r;

  function automatic logic [3:0] strobe_f(input logic st, input logic [1:0] sz,
                                          input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    if (st) begin
      case (sz)
        2'd0:    s = 4'b0001 << off;
        2'd1:    s = 4'b0011 << off;
        2'd2:    s = 4'b1111;
        default: s = 4'b0000;
      endcase
    end else begin
      s = 4'b0000;
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] wdata_f(input logic [1:0] sz,
                                                input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (sz)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Operation decode: direction and access size
  always_comb begin
    is_ld_s = 1'b0;
    is_st_s = 1'b0;
    size_s  = 2'd0;
    case (oper)
      OP_LB, OP_LBU: begin is_ld_s = 1'b1; size_s = 2'd0; end
      OP_LH, OP_LHU: begin is_ld_s = 1'b1; size_s = 2'd1; end
      OP_LW:         begin is_ld_s = 1'b1; size_s = 2'd2; end
      OP_SB:         begin is_st_s = 1'b1; size_s = 2'd0; end
      OP_SH:         begin is_st_s = 1'b1; size_s = 2'd1; end
      OP_SW:         begin is_st_s = 1'b1; size_s = 2'd2; end
      default:       begin is_ld_s = 1'b0; is_st_s = 1'b0; size_s = 2'd0; end
    endcase
  end

  assign misalign_s = ((size_s == 2'd1) && addr[0]) ||
                      ((size_s == 2'd2) && (addr[1:0] != 2'b00));
  assign addr_err   = mem_en && (is_ld_s || is_st_s) && misalign_s;
  assign start_s    = mem_en && !addr_err && !flush && (state_r == S_IDLE);
  assign finish_s   = (state_r == S_WAIT) && bus.data_data_ok;
  // A flush arriving in the very cycle data returns still discards the result
  assign cancel_s   = cancel_r || flush;
  assign ld_cap_s   = finish_s && !wr_r && !cancel_s;

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) next_s = S_REQ;
        else         next_s = S_IDLE;
      end
      S_REQ: begin
        if (bus.data_addr_ok) next_s = S_WAIT;
        else                  next_s = S_REQ;
      end
      S_WAIT: begin
        if (finish_s) next_s = cancel_s ? S_IDLE : S_DONE;
        else          next_s = S_WAIT;
      end
      S_DONE: begin
        if (flush || !hold) next_s = S_IDLE;
        else                next_s = S_DONE;
      end
      default: next_s = S_IDLE;
    endcase
  end

  // State, cancel flag, latched request fields and captured load word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cancel_r  <= 1'b0;
      req_r     <= 1'b0;
      wr_r      <= 1'b0;
      size_r    <= 2'd0;
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= 4'b0000;
      offset_r  <= 2'd0;
      ld_word_r <= '0;
    end else begin
      state_r <= next_s;
      req_r   <= (next_s == S_REQ);
      if (next_s == S_IDLE) begin
        cancel_r <= 1'b0;
      end else if (flush && ((state_r == S_REQ) || (state_r == S_WAIT))) begin
        cancel_r <= 1'b1;
      end
      if (start_s) begin
        wr_r     <= is_st_s;
        size_r   <= size_s;
        addr_r   <= {addr[ADDR_W-1:2], 2'b00};
        wdata_r  <= wdata_f(size_s, st_data);
        wstrb_r  <= strobe_f(is_st_s, size_s, addr[1:0]);
        offset_r <= addr[1:0];
      end
      if (ld_cap_s) begin
        ld_word_r <= bus.data_rdata;
      end
    end
  end

  assign stall_req      = start_s || (state_r == S_REQ) || (state_r == S_WAIT);
  assign bus.data_req   = req_r;
  assign bus.data_wr    = wr_r;
  assign bus.data_size  = size_r;
  assign bus.data_addr  = addr_r;
  assign bus.data_wdata = wdata_r;
  assign bus.data_wstrb = wstrb_r;
  assign ld_word        = ld_word_r;
  assign word_offset    = offset_r;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: table of single transactions with a scripted
// slave, plus flush-in-WAIT and reset-in-REQ sequences.
module tb_dmem_access;
  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n, mem_en, flush, hold;
  logic [3:0]  oper;
  logic [31:0] addr, st_data;
  logic        stall_req, addr_err;
  logic [31:0] ld_word;
  logic [1:0]  word_offset;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_ld = 32'h0;

  dmem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .oper(oper), .mem_en(mem_en), .flush(flush),
    .hold(hold), .addr(addr), .st_data(st_data), .stall_req(stall_req),
    .addr_err(addr_err), .bus(bus.master), .ld_word(ld_word),
    .word_offset(word_offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  oper;
    logic [31:0] addr;
    logic [31:0] st_data;
    int          da;       // cycles addr_ok is withheld
    int          dd;       // extra WAIT cycles before data_ok
    logic [31:0] rdata;
    int          hold_c;   // cycles hold stays high in DONE
    logic        exp_err;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_off;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    stall_n;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    oper = v.oper; addr = v.addr; st_data = v.st_data; mem_en = 1'b1;
    #1;
    chk({tag, "_err"}, 32'(addr_err), 32'(v.exp_err));
    if (v.exp_err) begin
      chk({tag, "_err_stall"}, 32'(stall_req), 32'h0);
      @(negedge clk);
      chk({tag, "_err_noreq"}, 32'(bus.data_req), 32'h0);
      mem_en = 1'b0;
      return;
    end
    stall_n = 32'(stall_req);
    @(negedge clk);
    chk({tag, "_req"}, 32'(bus.data_req), 32'h1);
    chk({tag, "_addr"}, bus.data_addr, v.exp_addr);
    chk({tag, "_wr"}, 32'(bus.data_wr), 32'(v.exp_wr));
    chk({tag, "_size"}, 32'(bus.data_size), 32'(v.exp_size));
    chk({tag, "_wstrb"}, 32'(bus.data_wstrb), 32'(v.exp_wstrb));
    if (v.exp_wr) chk({tag, "_wdata"}, bus.data_wdata, v.exp_wdata);
    stall_n += 32'(stall_req);
    for (int i = 0; i < v.da; i++) begin
      bus.data_addr_ok = 1'b0;
      @(negedge clk);
      chk({tag, "_req_held"}, 32'(bus.data_req), 32'h1);
      chk({tag, "_addr_stable"}, bus.data_addr, v.exp_addr);
      stall_n += 32'(stall_req);
    end
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.data_req), 32'h0);
    stall_n += 32'(stall_req);
    for (int i = 0; i < v.dd; i++) begin
      @(negedge clk);
      stall_n += 32'(stall_req);
    end
    bus.data_data_ok = 1'b1;
    bus.data_rdata = v.rdata;
    hold = (v.hold_c > 0);
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    bus.data_rdata = 32'h0;
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(3 + v.da + v.dd));
    chk({tag, "_done_stall"}, 32'(stall_req), 32'h0);
    if (!v.exp_wr) model_ld = v.rdata;
    chk({tag, "_ld_word"}, ld_word, model_ld);
    if (!v.exp_wr) chk({tag, "_offset"}, 32'(word_offset), 32'(v.exp_off));
    for (int i = 0; i < v.hold_c; i++) begin
      @(negedge clk);
      chk({tag, "_hold_stall"}, 32'(stall_req), 32'h0);
      chk({tag, "_hold_noreq"}, 32'(bus.data_req), 32'h0);
      chk({tag, "_hold_ld"}, ld_word, model_ld);
    end
    hold = 1'b0;
    mem_en = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_noreq"}, 32'(bus.data_req), 32'h0);
    chk({tag, "_idle_stall"}, 32'(stall_req), 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(bus.data_req), 32'h0);
    chk({tag, "_stall"}, 32'(stall_req), 32'h0);
    chk({tag, "_wr"}, 32'(bus.data_wr), 32'h0);
    chk({tag, "_size"}, 32'(bus.data_size), 32'h0);
    chk({tag, "_addr"}, bus.data_addr, 32'h0);
    chk({tag, "_wdata"}, bus.data_wdata, 32'h0);
    chk({tag, "_wstrb"}, 32'(bus.data_wstrb), 32'h0);
    chk({tag, "_ld"}, ld_word, 32'h0);
    chk({tag, "_off"}, 32'(word_offset), 32'h0);
  endtask

  initial begin
    //        oper    addr          st_data       da dd rdata         hc err wr sz wstrb    wdata         exp_addr      off
    vecs[0]  = '{OP_SB,  32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0,         0, 1'b0, 1'b1, 2'd0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, 2'd3};
    vecs[1]  = '{OP_LW,  32'h0000_2000, 32'h0,         2, 2, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,         32'h0000_2000, 2'd0};
    vecs[2]  = '{OP_LH,  32'h0000_2001, 32'h0,         0, 0, 32'h0,         0, 1'b1, 1'b0, 2'd1, 4'b0000, 32'h0,         32'h0,         2'd1};
    vecs[3]  = '{OP_SH,  32'h0000_2002, 32'h0000_1234, 0, 0, 32'h0,         0, 1'b0, 1'b1, 2'd1, 4'b1100, 32'h1234_1234, 32'h0000_2000, 2'd2};
    vecs[4]  = '{OP_SW,  32'h0000_4002, 32'h0,         0, 0, 32'h0,         0, 1'b1, 1'b1, 2'd2, 4'b0000, 32'h0,         32'h0,         2'd2};
    vecs[5]  = '{OP_LW,  32'h0000_4001, 32'h0,         0, 0, 32'h0,         0, 1'b1, 1'b0, 2'd2, 4'b0000, 32'h0,         32'h0,         2'd1};
    vecs[6]  = '{OP_SB,  32'h0000_1001, 32'hFFFF_FF5A, 1, 0, 32'h0,         0, 1'b0, 1'b1, 2'd0, 4'b0010, 32'h5A5A_5A5A, 32'h0000_1000, 2'd1};
    vecs[7]  = '{OP_SH,  32'h0000_3000, 32'hFFFF_BEEF, 0, 1, 32'h0,         0, 1'b0, 1'b1, 2'd1, 4'b0011, 32'hBEEF_BEEF, 32'h0000_3000, 2'd0};
    vecs[8]  = '{OP_LBU, 32'h0000_3002, 32'h0,         0, 0, 32'h1122_3344, 0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,         32'h0000_3000, 2'd2};
    vecs[9]  = '{OP_LHU, 32'h0000_5006, 32'h0,         1, 1, 32'h5566_7788, 0, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0,         32'h0000_5004, 2'd2};
    vecs[10] = '{OP_SW,  32'h0000_6004, 32'hCAFE_F00D, 0, 0, 32'h0,         0, 1'b0, 1'b1, 2'd2, 4'b1111, 32'hCAFE_F00D, 32'h0000_6004, 2'd0};
    vecs[11] = '{OP_LB,  32'h0000_7003, 32'h0,         0, 0, 32'h99AA_BBCC, 0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,         32'h0000_7000, 2'd3};
    vecs[12] = '{OP_LW,  32'h0000_8000, 32'h0,         0, 0, 32'h0BAD_F00D, 2, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,         32'h0000_8000, 2'd0};
    vecs[13] = '{OP_SW,  32'h0000_9008, 32'h8765_4321, 0, 0, 32'h0,         0, 1'b0, 1'b1, 2'd2, 4'b1111, 32'h8765_4321, 32'h0000_9008, 2'd0};

    rst_n = 1'b0; mem_en = 1'b0; flush = 1'b0; hold = 1'b0;
    oper = OP_NOP; addr = 32'h0; st_data = 32'h0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Flush in WAIT during LBU: result discarded, FSM back in IDLE, no re-issue
    @(negedge clk);
    oper = OP_LBU; addr = 32'h0000_3002; mem_en = 1'b1;
    #1 chk("fl_start_stall", 32'(stall_req), 32'h1);
    @(negedge clk);
    chk("fl_req", 32'(bus.data_req), 32'h1);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    flush = 1'b1; mem_en = 1'b0;
    chk("fl_wait_stall", 32'(stall_req), 32'h1);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_wait_stall2", 32'(stall_req), 32'h1);
    chk("fl_noreq", 32'(bus.data_req), 32'h0);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1122_3344;
    @(negedge clk);
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    chk("fl_ld_kept", ld_word, model_ld);
    chk("fl_after_stall", 32'(stall_req), 32'h0);
    oper = OP_SB; addr = 32'h0000_1000; mem_en = 1'b1;
    #1 chk("fl_idle_start", 32'(stall_req), 32'h1);
    mem_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("fl_no_second_req", 32'(bus.data_req), 32'h0);
    end

    // Reset while a SW sits in REQ
    @(negedge clk);
    oper = OP_SW; addr = 32'h0000_A000; st_data = 32'h1357_9BDF; mem_en = 1'b1;
    @(negedge clk);
    chk("rst_req_before", 32'(bus.data_req), 32'h1);
    rst_n = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    rst_n = 1'b1;
    model_ld = 32'h0;
    run_vec(vecs[13], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
